// File: rtl/bcd_pkg.sv
// bcd_pkg: shared defaults, FSM state type and BCD digit check for the BCD-to-binary converter.
package bcd_pkg;
  localparam int DEF_DIGITS = 4;
  localparam int DEF_BIN_W = 14;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: reverse double-dabble correction, subtracts 3 from a digit that is 8 or more.
module bcd_digit_adj (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);
  assign o_d = i_d >= 4'd8 ? i_d - 4'd3 : i_d;
endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: serial packed-BCD to binary converter using reverse double-dabble.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W = DEF_BIN_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [BIN_W-1:0]    bin_out
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);
  state_t            r_state;
  logic [BW-1:0]     r_bcd;
  logic [BIN_W-1:0]  r_bin;
  logic [CW-1:0]     r_cnt;
  logic [BIN_W-1:0]  r_bin_out;
  logic              r_err;
  logic [BW-1:0]     w_bcd_sh;
  logic [BW-1:0]     w_bcd_adj;
  logic [BIN_W-1:0]  w_bin_sh;
  logic              w_valid;
  logic              w_accept;
  assign w_bcd_sh = {1'b0, r_bcd[BW-1:1]};
  assign w_bin_sh = {r_bcd[0], r_bin[BIN_W-1:1]};
  assign w_accept = start && r_state != S_SHIFT;
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (.i_d(w_bcd_sh[4*g+:4]), .o_d(w_bcd_adj[4*g+:4]));
    end
  endgenerate
  always_comb begin
    w_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (!digit_ok(bcd_in[4*i+:4])) w_valid = 1'b0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_bin_out <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_bcd <= bcd_in;
      r_bin <= '0;
      r_cnt <= '0;
      if (w_valid) r_state <= S_SHIFT;
      else begin
        r_state   <= S_DONE;
        r_bin_out <= '0;
        r_err     <= 1'b1;
      end
    end else if (r_state == S_SHIFT) begin
      r_bcd <= w_bcd_adj;
      r_bin <= w_bin_sh;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == LAST) begin
        r_state   <= S_DONE;
        r_bin_out <= w_bin_sh;
        r_err     <= 1'b0;
      end
    end else if (r_state == S_DONE) r_state <= S_IDLE;
  end
  assign busy    = r_state == S_SHIFT;
  assign done    = r_state == S_DONE;
  assign err     = r_err;
  assign bin_out = r_bin_out;
endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: table-driven, hand-sequenced and random checks of bcd_to_bin against a decimal model.
module tb_bcd_to_bin;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        busy, done, err;
  logic [13:0] bin_out;
  int n_vec = 0;
  int n_err = 0;
  bcd_to_bin dut (
    .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .err(err), .bin_out(bin_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] bcd;
    int          bin;
    logic        bad;
    int          lat;
    int          nbusy;
  } vec_t;
  vec_t tbl[10];
  // Decimal value of a packed BCD word, or -1 if any digit is not 0..9.
  function automatic int bcd_ref(input logic [15:0] v);
    int acc = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int d = int'(v[4*i+:4]);
      if (d > 9) return -1;
      acc += d * w;
      w *= 10;
    end
    return acc;
  endfunction
  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic start_conv(input logic [15:0] v);
    start = 1'b1;
    bcd_in = v;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int lat, output int nbusy);
    lat = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(posedge clk);
      #1 lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask
  task automatic one_shot(input string name);
    @(posedge clk);
    #1 chk(name, int'(done), 0);
  endtask
  initial begin
    int lat, nb, exp;
    logic [15:0] v;
    #200000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int lat, nb, exp;
    logic [15:0] v;
    tbl[0] = '{16'h9999, 9999, 1'b0, 15, 14};
    tbl[1] = '{16'h0000, 0, 1'b0, 15, 14};
    tbl[2] = '{16'h1234, 1234, 1'b0, 15, 14};
    tbl[3] = '{16'h0001, 1, 1'b0, 15, 14};
    tbl[4] = '{16'h12A4, 0, 1'b1, 1, 0};
    tbl[5] = '{16'h8765, 8765, 1'b0, 15, 14};
    tbl[6] = '{16'hF000, 0, 1'b1, 1, 0};
    tbl[7] = '{16'h0042, 42, 1'b0, 15, 14};
    tbl[8] = '{16'h5009, 5009, 1'b0, 15, 14};
    tbl[9] = '{16'h000A, 0, 1'b1, 1, 0};
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_bin", int'(bin_out), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    foreach (tbl[k]) begin
      start_conv(tbl[k].bcd);
      wait_done(lat, nb);
      chk($sformatf("tbl%0d_bin", k), int'(bin_out), tbl[k].bin);
      chk($sformatf("tbl%0d_err", k), int'(err), int'(tbl[k].bad));
      chk($sformatf("tbl%0d_lat", k), lat, tbl[k].lat);
      chk($sformatf("tbl%0d_busy", k), nb, tbl[k].nbusy);
      one_shot($sformatf("tbl%0d_pulse", k));
      chk($sformatf("tbl%0d_hold", k), int'(bin_out), tbl[k].bin);
    end
    start_conv(16'h0000);
    wait_done(lat, nb);
    chk("b2b_first_bin", int'(bin_out), 0);
    start_conv(16'h1234);
    chk("b2b_done_drop", int'(done), 0);
    chk("b2b_busy", int'(busy), 1);
    wait_done(lat, nb);
    chk("b2b_second_bin", int'(bin_out), 1234);
    chk("b2b_second_lat", lat, 15);
    one_shot("b2b_pulse");
    start_conv(16'h0042);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start_conv(16'h0001);
    wait_done(lat, nb);
    chk("ign_bin", int'(bin_out), 42);
    chk("ign_lat", lat, 10);
    one_shot("ign_pulse");
    start_conv(16'h0777);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_bin", int'(bin_out), 0);
    nb = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done) nb++;
    end
    chk("abort_no_done", nb, 0);
    reset = 1'b1;
    start_conv(16'h0500);
    wait_done(lat, nb);
    chk("abort_restart_bin", int'(bin_out), 500);
    chk("abort_restart_lat", lat, 15);
    one_shot("abort_pulse");
    for (int r = 0; r < 30; r++) begin
      v = {4'($urandom_range(1, 9)), 4'($urandom_range(0, 9)),
           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if (r % 6 == 5) v[4*$urandom_range(0, 3)+:4] = 4'($urandom_range(10, 15));
      exp = bcd_ref(v);
      start_conv(v);
      wait_done(lat, nb);
      chk($sformatf("rnd_%h_bin", v), int'(bin_out), exp < 0 ? 0 : exp);
      chk($sformatf("rnd_%h_err", v), int'(err), exp < 0 ? 1 : 0);
      chk($sformatf("rnd_%h_lat", v), lat, exp < 0 ? 1 : 15);
      one_shot($sformatf("rnd_%h_pulse", v));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameters SHALL be as follows.
- DIGITS, default 4: number of packed BCD digits.
- BIN_W, default 14: binary result width; SHALL satisfy 2^BIN_W >= 10^DIGITS.

REQ-002 Ports SHALL be as follows.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  conversion request.
- bcd_in  in  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- busy  out  1  conversion in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  last accepted input had a digit >9.
- bin_out  out  BIN_W  binary result.

REQ-003 The block SHALL have one clock. Reset SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL convert packed BCD to unsigned binary serially, using reverse double-dabble (shift-right / subtract-3).

REQ-005 The state machine SHALL have three states: IDLE, SHIFT and DONE.

REQ-006 Start acceptance:
- start SHALL be accepted on a rising edge when the state is IDLE or DONE.
- On acceptance, bcd_in SHALL be captured into a 4*DIGITS working register.
- start SHALL be ignored while in SHIFT.

REQ-007 Valid input on the accept edge: state goes to SHIFT, iteration counter is cleared, and the BIN_W-bit binary shift register is cleared.

REQ-008 Invalid input (any digit >9) on the accept edge: state goes to DONE, bin_out is set to 0, err is set to 1, and no shifting occurs.

REQ-009 Each SHIFT cycle SHALL perform one step:
- Shift {bcd_reg, bin_reg} right by 1; the bcd_reg LSB enters the bin_reg MSB.
- Then, for each digit of the shifted bcd_reg that is >=8, subtract 3.

REQ-010 SHIFT SHALL last exactly BIN_W cycles, tracked by a counter of width clog2(BIN_W+1).
- On the BIN_W-th shift edge, the state goes to DONE, bin_out is loaded from the final bin_reg, and err is cleared.

REQ-011 Handshake outputs:
- busy SHALL be 1 exactly while the state is SHIFT.
- done SHALL be 1 exactly while the state is DONE, which lasts one cycle.
- DONE SHALL go to IDLE unless start is accepted on that edge.

REQ-012 Latency for valid input: done SHALL be high in the cycle after edge BIN_W following the accept edge (default: 14 cycles of busy, then 1 cycle of done).

REQ-013 bin_out and err SHALL hold their values until the next conversion completes or is rejected.

REQ-014 Back-to-back: start asserted during DONE SHALL be accepted.
- The new conversion begins on that edge.
- done still pulses for exactly one cycle.

REQ-015 Results SHALL be exact for all valid inputs 0..10^DIGITS-1. bin_out SHALL NOT wrap.

Reset
REQ-016 While reset=0, asynchronously:
- State SHALL be IDLE.
- busy, done and err SHALL be 0.
- bin_out, working registers and counter SHALL be 0.

REQ-017 Reset asserted mid-SHIFT SHALL abort the conversion.
- No done pulse SHALL follow.
- The first edge after release SHALL be able to accept start.

Structure
REQ-018 Package bcd_pkg SHALL hold:
- DIGITS and BIN_W default constants.
- The state enum (IDLE, SHIFT, DONE).
- A digit-valid (<=9) function.

REQ-019 Sub-module bcd_digit_adj SHALL be combinational: 4-bit in, 4-bit out, out = in>=8 ? in-3 : in. It SHALL be instantiated DIGITS times via generate.

REQ-020 All state, counters and outputs SHALL be registered; done and busy SHALL be decoded from state only.

Verification
REQ-021 Accept bcd_in=16'h9999 -> busy for 14 cycles, then done=1 for 1 cycle, bin_out=14'd9999 (0x270F), err=0.

REQ-022 Accept bcd_in=16'h0000, then 16'h1234 back-to-back during DONE -> bin_out=0, then bin_out=1234 (0x04D2); two single-cycle done pulses.

REQ-023 Accept bcd_in=16'h12A4 -> done=1 on the cycle after the accept edge, err=1, bin_out=0, busy never asserts.

REQ-024 Start pulsed again at cycle 5 of SHIFT with bcd_in=16'h0001 -> ignored; original input 16'h0042 yields bin_out=42.

REQ-025 Reset driven low at cycle 7 of SHIFT -> busy=0 and done=0 immediately, bin_out=0, no done pulse; a following start with 16'h0500 yields 500.

REQ-026 Random valid 4-digit inputs (>=1000) -> bin_out equals the decimal value, with fixed 15-cycle start-to-done latency.
